// File: rtl/thor2022_pkg.sv
// Shared Thor2022 compare definitions: result bit positions, FSM state type
// and the flag-to-result-vector encoder.
package thor2022_pkg;

    localparam int CMP_EQ  = 0;
    localparam int CMP_LT  = 1;
    localparam int CMP_LE  = 2;
    localparam int CMP_LTU = 5;
    localparam int CMP_LEU = 6;
    localparam int CMP_NE  = 8;
    localparam int CMP_GE  = 9;
    localparam int CMP_GT  = 10;

    localparam int CMP_CODE_W = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } cmp_state_t;

    // Signed ordering only differs from unsigned when the sign bits disagree.
    function automatic logic [CMP_CODE_W-1:0] cmp_encode(
        input logic eq,
        input logic ltu,
        input logic sa,
        input logic sb
    );
        logic                  lts;
        logic [CMP_CODE_W-1:0] r;
        lts = (sa != sb) ? sa : ltu;
        r = 16'h0000;
        r[CMP_EQ]  = eq;
        r[CMP_LT]  = lts;
        r[CMP_LE]  = lts | eq;
        r[CMP_LTU] = ltu;
        r[CMP_LEU] = ltu | eq;
        r[CMP_NE]  = ~eq;
        r[CMP_GE]  = ~lts;
        r[CMP_GT]  = ~lts & ~eq;
        return r;
    endfunction

endpackage

// File: rtl/thor2022_slice_cmp.sv
// Combinational unsigned compare of one SLICE-bit operand slice.
module thor2022_slice_cmp #(
    parameter int SLICE = 32
) (
    input  logic [SLICE-1:0] slice_a,
    input  logic [SLICE-1:0] slice_b,
    output logic             eq,
    output logic             ltu
);

    assign eq  = (slice_a == slice_b);
    assign ltu = (slice_a <  slice_b);

endmodule

// File: rtl/thor2022_compare_seq.sv
// Sequential MSB-first sliced integer compare for Thor2022.
// Optional feature macro: THOR_CMP_EARLY_EXIT_EN (stop at first differing slice).
module thor2022_compare_seq
    import thor2022_pkg::*;
#(
    parameter int WID   = 128,
    parameter int SLICE = 32
) (
    input  logic           clk_i,
    input  logic           rst_ni,
    input  logic           req_i,
    input  logic           abort_i,
    input  logic [WID-1:0] a_i,
    input  logic [WID-1:0] b_i,
    output logic           rdy_o,
    output logic           done_o,
    output logic [WID-1:0] o_o
);

    localparam int NSLICE = WID / SLICE;
    localparam int IDXW   = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam logic [IDXW-1:0] IDX_TOP = IDXW'(NSLICE - 1);

`ifdef THOR_CMP_EARLY_EXIT_EN
    localparam logic EARLY_EXIT = 1'b1;
`else
    localparam logic EARLY_EXIT = 1'b0;
`endif

    cmp_state_t      state_r;
    logic [IDXW-1:0] idx_r;
    logic [WID-1:0]  a_r;
    logic [WID-1:0]  b_r;
    logic            sa_r;
    logic            sb_r;
    logic            eq_r;
    logic            ltu_r;
    logic            found_r;
    logic            rdy_r;
    logic            done_r;
    logic [WID-1:0]  o_r;

    logic [SLICE-1:0] a_sl_s [NSLICE];
    logic [SLICE-1:0] b_sl_s [NSLICE];
    logic [SLICE-1:0] slice_a_s;
    logic [SLICE-1:0] slice_b_s;
    logic             slice_eq_s;
    logic             slice_ltu_s;
    logic             nxt_eq_s;
    logic             nxt_ltu_s;
    logic             nxt_found_s;
    logic             leave_s;

    for (genvar g = 0; g < NSLICE; g++) begin : g_slices
        assign a_sl_s[g] = a_r[g*SLICE +: SLICE];
        assign b_sl_s[g] = b_r[g*SLICE +: SLICE];
    end

    assign slice_a_s = a_sl_s[idx_r];
    assign slice_b_s = b_sl_s[idx_r];

    thor2022_slice_cmp #(
        .SLICE (SLICE)
    ) u_slice_cmp (
        .slice_a (slice_a_s),
        .slice_b (slice_b_s),
        .eq      (slice_eq_s),
        .ltu     (slice_ltu_s)
    );

    // Flag update for this SCAN cycle; the first differing slice is sticky.
    always_comb begin
        nxt_eq_s    = eq_r;
        nxt_ltu_s   = ltu_r;
        nxt_found_s = found_r;
        if (!found_r && !slice_eq_s) begin
            nxt_eq_s    = 1'b0;
            nxt_ltu_s   = slice_ltu_s;
            nxt_found_s = 1'b1;
        end else begin
            nxt_found_s = found_r;
        end
        leave_s = (idx_r == {IDXW{1'b0}}) || (EARLY_EXIT && !slice_eq_s);
    end

    // Control FSM with operand capture, slice index and registered outputs.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_r <= IDLE;
            idx_r   <= {IDXW{1'b0}};
            a_r     <= {WID{1'b0}};
            b_r     <= {WID{1'b0}};
            sa_r    <= 1'b0;
            sb_r    <= 1'b0;
            eq_r    <= 1'b0;
            ltu_r   <= 1'b0;
            found_r <= 1'b0;
            rdy_r   <= 1'b1;
            done_r  <= 1'b0;
            o_r     <= {WID{1'b0}};
        end else begin
            case (state_r)
                IDLE: begin
                    done_r <= 1'b0;
                    if (req_i && !abort_i) begin
                        a_r     <= a_i;
                        b_r     <= b_i;
                        sa_r    <= a_i[WID-1];
                        sb_r    <= b_i[WID-1];
                        idx_r   <= IDX_TOP;
                        eq_r    <= 1'b1;
                        ltu_r   <= 1'b0;
                        found_r <= 1'b0;
                        rdy_r   <= 1'b0;
                        state_r <= SCAN;
                    end else begin
                        rdy_r <= 1'b1;
                    end
                end
                SCAN: begin
                    if (abort_i) begin
                        rdy_r   <= 1'b1;
                        done_r  <= 1'b0;
                        state_r <= IDLE;
                    end else begin
                        eq_r    <= nxt_eq_s;
                        ltu_r   <= nxt_ltu_s;
                        found_r <= nxt_found_s;
                        if (leave_s) begin
                            o_r     <= WID'(cmp_encode(nxt_eq_s, nxt_ltu_s, sa_r, sb_r));
                            done_r  <= 1'b1;
                            state_r <= DONE;
                        end else begin
                            idx_r <= idx_r - IDXW'(1);
                        end
                    end
                end
                DONE: begin
                    done_r  <= 1'b0;
                    rdy_r   <= 1'b1;
                    state_r <= IDLE;
                end
                default: begin
                    done_r  <= 1'b0;
                    rdy_r   <= 1'b1;
                    state_r <= IDLE;
                end
            endcase
        end
    end

    assign rdy_o  = rdy_r;
    assign done_o = done_r;
    assign o_o    = o_r;

endmodule

// File: tb/tb_thor2022_compare_seq.sv
// Scoreboard bench for thor2022_compare_seq (WID=128, SLICE=32).
module tb_thor2022_compare_seq;

    localparam int WID    = 128;
    localparam int SLICE  = 32;
    localparam int NSLICE = WID / SLICE;

`ifdef THOR_CMP_EARLY_EXIT_EN
    localparam bit EE = 1'b1;
`else
    localparam bit EE = 1'b0;
`endif

    typedef struct {
        logic [WID-1:0] o;
        int             cyc;
    } exp_t;

    logic           clk;
    logic           rst_ni;
    logic           req_i;
    logic           abort_i;
    logic [WID-1:0] a_i;
    logic [WID-1:0] b_i;
    logic           rdy_o;
    logic           done_o;
    logic [WID-1:0] o_o;

    exp_t           sb_q[$];
    int             cyc;
    int             checks;
    int             errors;
    logic [WID-1:0] last_exp;
    int             acc;

    thor2022_compare_seq #(
        .WID   (WID),
        .SLICE (SLICE)
    ) dut (
        .clk_i   (clk),
        .rst_ni  (rst_ni),
        .req_i   (req_i),
        .abort_i (abort_i),
        .a_i     (a_i),
        .b_i     (b_i),
        .rdy_o   (rdy_o),
        .done_o  (done_o),
        .o_o     (o_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk or negedge rst_ni) begin
        if (!rst_ni) cyc <= 0;
        else         cyc <= cyc + 1;
    end

    task automatic check(input string name, input logic [WID-1:0] act, input logic [WID-1:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    // Monitor: every done_o pulse must match the head of the scoreboard.
    always @(negedge clk) begin
        if (done_o) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got done_o=1 at cycle %0d expected none", cyc);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check("result", o_o, e.o);
                check("done_cycle", WID'(cyc), WID'(e.cyc));
            end
        end
    end

    // Waits (bounded) for rdy_o, then presents one request for one edge.
    task automatic start(input logic [WID-1:0] a, input logic [WID-1:0] b);
        int n;
        n = 0;
        @(negedge clk);
        while (!rdy_o && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!rdy_o) begin
            checks++;
            errors++;
            $display("FAIL rdy_timeout: got rdy_o=0 expected 1");
        end
        a_i   = a;
        b_i   = b;
        req_i = 1'b1;
        acc   = cyc;
        @(negedge clk);
        req_i = 1'b0;
    endtask

    // k: first differing slice from the top, -1 for equal operands.
    task automatic do_cmp(input logic [WID-1:0] a, input logic [WID-1:0] b,
                          input logic [WID-1:0] exp_o, input int k);
        exp_t e;
        int   lat;
        lat = (EE && k >= 0) ? k + 2 : NSLICE + 1;
        start(a, b);
        e.o   = exp_o;
        e.cyc = acc + lat;
        sb_q.push_back(e);
        last_exp = exp_o;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb_q.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (sb_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: got %0d pending expected 0", sb_q.size());
        end
    endtask

    initial begin
        rst_ni   = 1'b0;
        req_i    = 1'b0;
        abort_i  = 1'b0;
        a_i      = 128'd0;
        b_i      = 128'd0;
        checks   = 0;
        errors   = 0;
        last_exp = 128'd0;
        acc      = 0;
        #12;
        check("reset_rdy", WID'(rdy_o), 128'd1);
        check("reset_done", WID'(done_o), 128'd0);
        check("reset_o", o_o, 128'd0);
        @(negedge clk);
        rst_ni = 1'b1;

        do_cmp(128'h1234, 128'h1234, 128'h245, -1);
        do_cmp({128{1'b1}}, 128'd1, 128'h106, 0);
        do_cmp(128'd1, 128'd2, 128'h166, 3);
        do_cmp(128'd2, 128'd1, 128'h700, 3);
        do_cmp(128'd1 << 127, 128'd0, 128'h106, 0);
        do_cmp(128'd1 << 64, 128'd0, 128'h700, 1);
        do_cmp(128'd0, 128'd1 << 32, 128'h166, 2);
        do_cmp(128'd1 << 96, 128'hFFFF_FFFF, 128'h700, 0);
        drain();

        // Abort in cycle 2 of a full scan.
        start(128'd1, 128'd2);
        @(negedge clk);
        abort_i = 1'b1;
        @(negedge clk);
        abort_i = 1'b0;
        check("abort_rdy", WID'(rdy_o), 128'd1);
        check("abort_o_kept", o_o, last_exp);
        req_i   = 1'b1;
        abort_i = 1'b1;
        a_i     = 128'd3;
        b_i     = 128'd4;
        @(negedge clk);
        req_i   = 1'b0;
        abort_i = 1'b0;
        check("abort_blocks_req", WID'(rdy_o), 128'd1);
        repeat (8) @(negedge clk);
        check("abort_o_still", o_o, last_exp);

        // Reset in cycle 3 of a scan.
        start(128'd1, 128'd2);
        @(negedge clk);
        @(posedge clk);
        #1 rst_ni = 1'b0;
        #1;
        check("midrst_rdy", WID'(rdy_o), 128'd1);
        check("midrst_done", WID'(done_o), 128'd0);
        check("midrst_o", o_o, 128'd0);
        last_exp = 128'd0;
        @(negedge clk);
        rst_ni = 1'b1;
        do_cmp(128'd5, 128'd5, 128'h245, -1);
        drain();

        // Request during SCAN with other operands must be ignored.
        do_cmp(128'd1, 128'd2, 128'h166, 3);
        @(negedge clk);
        req_i = 1'b1;
        a_i   = 128'd2;
        b_i   = 128'd1;
        @(negedge clk);
        req_i = 1'b0;
        drain();
        repeat (8) @(negedge clk);
        check("ignored_req_o", o_o, 128'h166);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
